// File: rtl/mux_rr_pkg.sv
// Shared defaults and the round-robin grant search for mux_rr_fifo.
package mux_rr_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int CH_DEF     = 2;
  localparam int DEPTH_DEF  = 4;
  localparam int CNT_W_DEF  = 8;

  localparam int MAX_CH = 32;
  localparam int GNT_W  = 5;

  typedef struct packed {
    logic             found;
    logic [GNT_W-1:0] grant;
  } rr_gnt_t;

  // Lowest requester at or above ptr wins; if none, wrap to the lowest requester overall.
  function automatic rr_gnt_t rr_next(input logic [MAX_CH-1:0] req,
                                      input logic [GNT_W-1:0]  ptr);
    logic [MAX_CH-1:0] mask;
    logic [MAX_CH-1:0] masked;
    rr_gnt_t           r;
    mask   = ~((MAX_CH'(1) << ptr) - MAX_CH'(1));
    masked = req & mask;
    r      = '0;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (req[i]) begin
        r.found = 1'b1;
        r.grant = GNT_W'(i);
      end
    end
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (masked[i]) r.grant = GNT_W'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_rr_fifo_sync_fifo.sv
// Single-clock FIFO with combinational head; the caller never pushes when full
// unless it pops on the same edge, and never pops when empty.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic [CW-1:0]     cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage is left unreset; flushing the pointers discards the contents.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata;
  end

  assign rdata = mem[rptr];
  assign count = cnt;
  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);

endmodule

// File: rtl/mux_rr_fifo.sv
// CH-channel buffered round-robin valid-stream mux with overflow reporting.
// Optional saturating per-channel drop counters: define MUX_RR_DROP_CNT_EN.
module mux_rr_fifo
  import mux_rr_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CH     = CH_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [CH*DATA_W-1:0]   data_in,
  input  logic [CH-1:0]          valid_in,
  output logic [DATA_W-1:0]      data_out,
  output logic                   valid_out,
  output logic [$clog2(CH)-1:0]  ch_out,
  output logic [CH-1:0]          fifo_full,
  output logic [CH-1:0]          overflow
`ifdef MUX_RR_DROP_CNT_EN
  ,
  output logic [CH*CNT_W-1:0]    drop_cnt
`endif
);

  localparam int CH_W = $clog2(CH);
  localparam int CW   = $clog2(DEPTH) + 1;

  if (CH < 2 || CH > MAX_CH) begin : g_bad_ch
    $error("mux_rr_fifo: CH out of range");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("mux_rr_fifo: DEPTH must be a power of 2, at least 2");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("mux_rr_fifo: CNT_W must be positive");
  end

  logic [CH-1:0]     push_p0;
  logic [CH-1:0]     pop_p0;
  logic [CH-1:0]     drop_p0;
  logic [CH-1:0]     full_w;
  logic [CH-1:0]     empty_w;
  logic [DATA_W-1:0] head_w  [CH];
  logic [CW-1:0]     count_w [CH];
  logic [MAX_CH-1:0] req_p0;
  rr_gnt_t           gnt_p0;
  logic [DATA_W-1:0] sel_data_p0;
  logic [GNT_W-1:0]  ptr_nxt_p0;

  logic [CH_W-1:0]   ptr;
  logic [DATA_W-1:0] data_p1;
  logic              vld_p1;
  logic [CH_W-1:0]   ch_p1;
  logic [CH-1:0]     ovf_p1;

  for (genvar i = 0; i < CH; i++) begin : g_fifo
    sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push_p0[i]),
      .pop   (pop_p0[i]),
      .wdata (data_in[i*DATA_W +: DATA_W]),
      .rdata (head_w[i]),
      .count (count_w[i]),
      .full  (full_w[i]),
      .empty (empty_w[i])
    );
    assign fifo_full[i] = (count_w[i] == CW'(DEPTH));
  end

  // Stage p0: arbitrate on pre-edge FIFO state, then gate pushes against it.
  always_comb begin
    req_p0          = '0;
    req_p0[CH-1:0]  = ~empty_w;
    gnt_p0          = rr_next(req_p0, GNT_W'(ptr));
    pop_p0          = '0;
    sel_data_p0     = '0;
    for (int i = 0; i < CH; i++) begin
      if (gnt_p0.found && gnt_p0.grant == GNT_W'(i)) begin
        pop_p0[i]   = 1'b1;
        sel_data_p0 = head_w[i];
      end
    end
    ptr_nxt_p0 = (gnt_p0.grant == GNT_W'(CH - 1)) ? '0 : gnt_p0.grant + GNT_W'(1);
    push_p0    = valid_in & (~full_w | pop_p0);
    drop_p0    = valid_in & full_w & ~pop_p0;
  end

  // Stage p1: registered output, source tag and overflow pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr     <= '0;
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      ch_p1   <= '0;
      ovf_p1  <= '0;
    end else begin
      ovf_p1 <= drop_p0;
      vld_p1 <= gnt_p0.found;
      if (gnt_p0.found) begin
        data_p1 <= sel_data_p0;
        ch_p1   <= CH_W'(gnt_p0.grant);
        ptr     <= CH_W'(ptr_nxt_p0);
      end
    end
  end

  assign data_out  = data_p1;
  assign valid_out = vld_p1;
  assign ch_out    = ch_p1;
  assign overflow  = ovf_p1;

`ifdef MUX_RR_DROP_CNT_EN
  for (genvar i = 0; i < CH; i++) begin : g_drop_cnt
    logic [CNT_W-1:0] cnt_p1;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt_p1 <= '0;
      end else if (drop_p0[i] && cnt_p1 != '1) begin
        cnt_p1 <= cnt_p1 + CNT_W'(1);
      end
    end
    assign drop_cnt[i*CNT_W +: CNT_W] = cnt_p1;
  end
`endif

endmodule
